// File: rtl/fifo_rd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_pkg
// Description : Shared types and occupancy arithmetic for the FIFO read
//               stream adapter.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_rd_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

    localparam int OCC_W = 2;

    // True when a new read still fits in the 2-entry buffer once the word in
    // flight lands; pop is added on the right so nothing can underflow.
    function automatic logic has_room(
        input logic [OCC_W-1:0] occ,
        input logic             inflight,
        input logic             pop
    );
        logic [OCC_W:0] w_used;
        logic [OCC_W:0] w_limit;
        w_used  = {1'b0, occ} + {{OCC_W{1'b0}}, inflight};
        w_limit = {{OCC_W{1'b0}}, pop} + (OCC_W+1)'(2);
        return (w_used < w_limit);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_stream_adapter_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_stream_adapter_if
// Description : FIFO read port plus valid/ready stream bundle. The master
//               modport is the adapter, the slave modport is its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_rd_stream_adapter_if #(
    parameter int FIFO_WIDTH = 16
);

    logic [FIFO_WIDTH-1:0] fifo_data_out;
    logic                  fifo_empty;
    logic                  fifo_underflow;
    logic                  fifo_rd_en;
    logic [FIFO_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    modport master (
        input  fifo_data_out,
        input  fifo_empty,
        input  fifo_underflow,
        input  m_ready,
        output fifo_rd_en,
        output m_data,
        output m_valid
    );

    modport slave (
        output fifo_data_out,
        output fifo_empty,
        output fifo_underflow,
        output m_ready,
        input  fifo_rd_en,
        input  m_data,
        input  m_valid
    );

endinterface
`default_nettype wire

// File: rtl/fifo_rd_skid.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_skid
// Description : Two-entry circular skid buffer with push/pop/clear, exposing
//               occupancy and head data.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int FIFO_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic                  i_clear,
    input  logic [FIFO_WIDTH-1:0] i_data,
    output logic [OCC_W-1:0]      o_occ,
    output logic [FIFO_WIDTH-1:0] o_head
);

    logic [FIFO_WIDTH-1:0] r_mem [2];
    logic                  r_head;
    logic [OCC_W-1:0]      r_occ;
    logic                  w_wr_idx;

    // Tail sits one past head when one entry is held; with 0 or 2 held it
    // aliases head (when full, a push only happens alongside a pop).
    assign w_wr_idx = r_head ^ r_occ[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_head   <= 1'b0;
            r_occ    <= '0;
        end else if (i_clear) begin
            r_occ <= '0;
        end else begin
            if (i_push) begin
                r_mem[w_wr_idx] <= i_data;
            end
            if (i_pop) begin
                r_head <= ~r_head;
            end
            case ({i_push, i_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_occ  = r_occ;
    assign o_head = r_mem[r_head];

endmodule
`default_nettype wire

// File: rtl/fifo_rd_stream_adapter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_stream_adapter
// Description : Turns a 1-cycle-latency FIFO read port into a full-throughput
//               valid/ready stream, with flush, underflow sticky and beat count.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_stream_adapter
    import fifo_rd_pkg::*;
#(
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    fifo_rd_stream_adapter_if.master         bus,
    input  logic                             flush,
    input  logic                             clr_stats,
    output logic                             err_underflow,
    output logic [CNT_WIDTH-1:0]             word_cnt
);

    localparam logic [0:0] c_ST_RUN   = RUN;
    localparam logic [0:0] c_ST_FLUSH = FLUSH;

    logic [0:0]            r_state;
    logic                  r_inflight;
    logic                  r_err;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [OCC_W-1:0]      w_occ;
    logic [FIFO_WIDTH-1:0] w_head;
    logic                  w_run;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_clear;

    assign w_run   = (r_state == c_ST_RUN);
    assign w_pop   = bus.m_valid && bus.m_ready;
    // A word landing in the flush cycle is dropped together with the buffer.
    assign w_push  = r_inflight && w_run && !flush;
    assign w_clear = w_run && flush;

    // rst gates the request so it is low as soon as reset asserts.
    assign bus.fifo_rd_en = !rst && w_run && !flush && !bus.fifo_empty &&
                            has_room(w_occ, r_inflight, w_pop);

    assign bus.m_valid = w_run && (w_occ != '0);
    assign bus.m_data  = w_head;

    fifo_rd_skid #(
        .FIFO_WIDTH (FIFO_WIDTH)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (w_clear),
        .i_data  (bus.fifo_data_out),
        .o_occ   (w_occ),
        .o_head  (w_head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_ST_RUN;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= bus.fifo_rd_en;
            case (r_state)
                c_ST_RUN: begin
                    if (flush) begin
                        r_state <= c_ST_FLUSH;
                    end
                end
                c_ST_FLUSH: begin
                    if (!r_inflight && !flush) begin
                        r_state <= c_ST_RUN;
                    end
                end
                default: r_state <= c_ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
            r_cnt <= '0;
        end else begin
            if (bus.fifo_underflow) begin
                r_err <= 1'b1;
            end else if (clr_stats) begin
                r_err <= 1'b0;
            end

            if (clr_stats) begin
                r_cnt <= '0;
            end else if (w_pop && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign err_underflow = r_err;
    assign word_cnt      = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_rd_stream_adapter
// Description : Directed bench for the FIFO read stream adapter with a
//               behavioural 1-cycle-latency FIFO on the read side.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_stream_adapter;

    localparam int FIFO_WIDTH = 16;
    localparam int CNT_WIDTH  = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush;
    logic                 clr_stats;
    logic                 err_underflow;
    logic [CNT_WIDTH-1:0] word_cnt;

    fifo_rd_stream_adapter_if #(.FIFO_WIDTH(FIFO_WIDTH)) bus ();

    fifo_rd_stream_adapter #(
        .FIFO_WIDTH (FIFO_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .flush         (flush),
        .clr_stats     (clr_stats),
        .err_underflow (err_underflow),
        .word_cnt      (word_cnt)
    );

    always #5 clk = ~clk;

    // FIFO model: storage written by the stimulus, read with 1-cycle latency.
    logic [FIFO_WIDTH-1:0] mem [256];
    logic [7:0]            wr_ptr;
    logic [7:0]            rd_ptr = 8'd0;

    assign bus.fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (bus.fifo_rd_en) begin
            bus.fifo_data_out <= mem[rd_ptr];
            rd_ptr            <= rd_ptr + 8'd1;
        end
    end

    int n_checks = 0;
    int n_err    = 0;
    logic [FIFO_WIDTH-1:0] got [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input int n, input logic [FIFO_WIDTH-1:0] base);
        for (int k = 0; k < n; k++) begin
            mem[wr_ptr] = base + FIFO_WIDTH'(k);
            wr_ptr      = wr_ptr + 8'd1;
        end
    endtask

    task automatic collect(input int cycles);
        got.delete();
        for (int c = 0; c < cycles; c++) begin
            if (bus.m_valid && bus.m_ready) got.push_back(bus.m_data);
            tick();
        end
    endtask

    task automatic chk_seq(input string tag, input int n, input logic [FIFO_WIDTH-1:0] base);
        chk({tag, "_count"}, got.size(), n);
        for (int k = 0; k < n; k++) begin
            chk(tag, (k < got.size()) ? got[k] : 'x, base + FIFO_WIDTH'(k));
        end
    endtask

    initial begin
        int n_rd;
        rst                = 1'b1;
        flush              = 1'b0;
        clr_stats          = 1'b0;
        bus.m_ready        = 1'b0;
        bus.fifo_underflow = 1'b0;
        wr_ptr             = 8'd0;

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        chk("rst_valid", bus.m_valid, 0);
        chk("rst_rd_en", bus.fifo_rd_en, 0);
        rst = 1'b0;
        #1;
        chk("rst_data", bus.m_data, 0);
        chk("rst_cnt", word_cnt, 0);
        chk("rst_err", err_underflow, 0);

        // Burst of 4 with m_ready high: 4 reads, valid from 2 cycles later
        load(4, 16'h0001);
        bus.m_ready = 1'b1;
        #1;
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("burst_rd_en_c%0d", i), bus.fifo_rd_en, (i < 4));
            chk($sformatf("burst_valid_c%0d", i), bus.m_valid, (i >= 2 && i < 6));
            if (i >= 2 && i < 6) chk($sformatf("burst_data_c%0d", i), bus.m_data, i - 1);
            tick();
        end
        chk("burst_cnt", word_cnt, 4);

        // Backpressure: only 2 reads, head stable, then all 8 in order
        bus.m_ready = 1'b0;
        load(8, 16'h0101);
        #1;
        n_rd = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.fifo_rd_en) n_rd++;
            if (i >= 2) begin
                chk($sformatf("bp_valid_c%0d", i), bus.m_valid, 1);
                chk($sformatf("bp_data_c%0d", i), bus.m_data, 16'h0101);
            end
            tick();
        end
        chk("bp_rd_pulses", n_rd, 2);
        bus.m_ready = 1'b1;
        #1;
        collect(16);
        chk_seq("bp_drain", 8, 16'h0101);
        chk("bp_cnt", word_cnt, 12);

        // FIFO empty: no reads, no output, no error
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("empty_c%0d", i), {bus.fifo_rd_en, bus.m_valid}, 2'b00);
            tick();
        end
        chk("empty_err", err_underflow, 0);

        // Flush while a word is in flight and one is being popped
        load(6, 16'h0201);
        #1;
        chk("fl_rd_c0", bus.fifo_rd_en, 1);
        tick();
        tick();
        chk("fl_valid_c2", bus.m_valid, 1);
        chk("fl_data_c2", bus.m_data, 16'h0201);
        flush = 1'b1;
        #1;
        chk("fl_rd_forced0", bus.fifo_rd_en, 0);
        tick();
        chk("fl_valid_off", bus.m_valid, 0);
        chk("fl_rd_off", bus.fifo_rd_en, 0);
        flush = 1'b0;
        #1;
        chk("fl_rd_still_off", bus.fifo_rd_en, 0);
        tick();
        chk("fl_rd_resume", bus.fifo_rd_en, 1);
        collect(10);
        chk_seq("fl_after", 4, 16'h0203);
        chk("fl_cnt", word_cnt, 17);

        // Underflow sticky and clear behaviour
        bus.fifo_underflow = 1'b1;
        #1;
        chk("uf_not_yet", err_underflow, 0);
        tick();
        bus.fifo_underflow = 1'b0;
        chk("uf_set", err_underflow, 1);
        tick();
        tick();
        chk("uf_held", err_underflow, 1);
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        chk("clr_err", err_underflow, 0);
        chk("clr_cnt", word_cnt, 0);
        clr_stats          = 1'b1;
        bus.fifo_underflow = 1'b1;
        tick();
        clr_stats          = 1'b0;
        bus.fifo_underflow = 1'b0;
        chk("uf_set_wins", err_underflow, 1);
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        chk("clr_err2", err_underflow, 0);

        // clr_stats coinciding with a pop leaves the counter at 0
        load(2, 16'h0301);
        #1;
        tick();
        tick();
        chk("cp_data", bus.m_data, 16'h0301);
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        chk("cp_cnt_zero", word_cnt, 0);
        chk("cp_data2", bus.m_data, 16'h0302);
        tick();
        chk("cp_cnt_one", word_cnt, 1);

        // Asynchronous reset mid-burst
        load(8, 16'h0401);
        #1;
        tick();
        tick();
        tick();
        chk("ar_data_pre", bus.m_data, 16'h0402);
        rst = 1'b1;
        #1;
        chk("ar_valid", bus.m_valid, 0);
        chk("ar_rd_en", bus.fifo_rd_en, 0);
        chk("ar_data", bus.m_data, 0);
        chk("ar_cnt", word_cnt, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("ar_rd_resume", bus.fifo_rd_en, 1);
        collect(12);
        chk_seq("ar_after", 5, 16'h0404);
        chk("ar_cnt_end", word_cnt, 5);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
